tex_fetch_unit: RTL and testbench
=================================

# tex_fetch_unit

Texel fetch responder for the GPU texturing path. It accepts texel halfword addresses from the texture address generator and issues VRAM halfword reads. It extracts the 4/8/16-bit texel from the returned halfword, resolves palette indices through a second CLUT read, and returns a 16-bit BGR555 texel. It sits between the texture address stage and the pixel pipeline, on the shared VRAM read port.

## Interface
Parameters:
- CACHE_EN, 1, enables the one-entry last-halfword hit register (0 = always read VRAM).

Ports:
- clk  in  1  system clock
- i_nRst  in  1  reset, asynchronous, active-low
- GPU_REG_TexFormat  in  2  0=4bit, 1=8bit, 2=16bit, 3=reserved (treated as 16bit)
- GPU_REG_CLUTX  in  6  CLUT X in 16-halfword units
- GPU_REG_CLUTY  in  9  CLUT line
- req_valid  in  1  texel request valid
- req_ready  out  1  block can accept a request
- req_adr  in  19  halfword address {V line, X halfword}
- req_subU  in  2  low U bits: [1:0] nibble select (4bit), [0] byte select (8bit), ignored (16bit)
- mem_req  out  1  VRAM read request, held until mem_ack
- mem_ack  in  1  request accepted this cycle
- mem_adr  out  19  VRAM halfword address
- mem_rvalid  in  1  read data valid (any latency ≥1 after ack, in order)
- mem_rdata  in  16  read halfword
- tex_valid  out  1  texel result valid
- tex_ready  in  1  consumer accepts result
- tex_color  out  16  texel colour (BGR555 + mask bit)
- tex_transparent  out  1  tex_color == 16'h0000

## Operation
- Registers are captured on request accept (req_valid & req_ready): format, CLUTX, CLUTY, req_adr, req_subU. Register changes during a fetch do not affect it.
- FSM states are IDLE, TEX_REQ, TEX_WAIT, CLUT_REQ, CLUT_WAIT, OUT.
- IDLE: req_ready=1. On accept:
  - cache hit (CACHE_EN, hit_valid, req_adr==hit_adr) → 16bit: OUT; 4/8bit: CLUT_REQ.
  - otherwise → TEX_REQ.
- TEX_REQ: mem_req=1, mem_adr=latched adr. On mem_ack → TEX_WAIT.
- TEX_WAIT: on mem_rvalid, store the halfword, set hit_adr/hit_valid, then go to OUT (16bit) or CLUT_REQ (4/8bit).
- Index extraction from halfword H:
  - 4bit: idx = H[4*sub+3 : 4*sub], zero-extended to 8 bits.
  - 8bit: idx = sub[0] ? H[15:8] : H[7:0].
- CLUT_REQ: mem_adr = {CLUTY, ({CLUTX,4'b0} + {2'b0,idx}) mod 1024}, so X wraps within the 1024-halfword line. mem_req=1. On mem_ack → CLUT_WAIT.
- CLUT_WAIT: on mem_rvalid, tex_color=rdata → OUT.
- OUT: tex_valid=1, outputs stable until tex_ready. On tex_ready → IDLE.
- The CLUT result is not cached. hit_valid clears on reset only; the system flushes by pulsing reset or driving CACHE_EN=0. VRAM writes are not snooped.
- mem_rvalid outside a WAIT state is ignored.

## Timing
- Reset values: req_ready=1, mem_req=0, mem_adr=0, tex_valid=0, tex_color=0, tex_transparent=1, hit_valid=0, state IDLE.
- All outputs are registered.
- Latency, accept to tex_valid, with a 1-cycle ack and 1-cycle rvalid:
  - 16bit miss: 4 cycles.
  - 4/8bit miss: 7 cycles.
  - 16bit hit: 1 cycle.
  - 4/8bit hit: 4 cycles.
- One request in flight at a time. req_ready=0 outside IDLE. No back-to-back accept on the tex_ready cycle; IDLE is re-entered first.
- mem_req/mem_adr stay stable while mem_ack=0.
- Reset mid-fetch aborts immediately, and any late mem_rvalid after reset is ignored. The memory arbiter is reset by the same i_nRst.

## Structure
- Shared GPU package: PIX_4BIT/PIX_8BIT/PIX_16BIT/PIX_RESERVED constants (used by the address generator too), FSM state enum.
- Sub-module texel_extract: combinational halfword + format + sub → 8-bit index or pass-through.

## Test plan
- 16bit miss: req_adr=0x12345, rdata=0x7C1F → one VRAM read at 0x12345, tex_color=0x7C1F, tex_transparent=0.
- 4bit: CLUTX=2, CLUTY=480, sub=3, H=0xA000 → idx=0xA, CLUT read at {9'd480,10'd42}, CLUT data 0x0000 → tex_transparent=1.
- 8bit CLUT wrap: CLUTX=63, sub=1, H=0x2000 → idx=0x20, CLUT X=(1008+32) mod 1024=16.
- Cache: two consecutive 16bit requests to 0x00100 → second has no mem_req, tex_valid 1 cycle after accept; with CACHE_EN=0, two reads.
- Backpressure: mem_ack low 5 cycles, tex_ready low 3 cycles → mem_req/mem_adr and tex_color held stable, req_ready=0 throughout.
- Reset asserted in CLUT_WAIT → all outputs at reset values asynchronously; subsequent stray mem_rvalid produces no tex_valid.

Source files
------------

// File: rtl/tex_fetch_unit_pkg.sv
// Shared GPU texturing definitions: texel format codes and the fetch FSM states.
package tex_fetch_unit_pkg;

  // Texel formats as programmed in GPU_REG_TexFormat (the address generator uses these too)
  localparam logic [1:0] PIX_4BIT     = 2'd0;
  localparam logic [1:0] PIX_8BIT     = 2'd1;
  localparam logic [1:0] PIX_16BIT    = 2'd2;
  localparam logic [1:0] PIX_RESERVED = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_TEX_REQ   = 3'd1,
    ST_TEX_WAIT  = 3'd2,
    ST_CLUT_REQ  = 3'd3,
    ST_CLUT_WAIT = 3'd4,
    ST_OUT       = 3'd5
  } fetch_state_t;

endpackage

// File: rtl/texel_extract.sv
// Picks the palette index out of a VRAM halfword for 4/8-bit texels.
// 16-bit and reserved formats are direct colour: no index, o_pal=0.
module texel_extract
  import tex_fetch_unit_pkg::*;
(
  input  logic [15:0] i_half,
  input  logic [1:0]  i_fmt,
  input  logic [1:0]  i_sub,
  output logic [7:0]  o_idx,
  output logic        o_pal
);

  // Nibble/byte select from the low U bits
  always_comb begin
    o_idx = 8'h00;
    o_pal = 1'b0;
    case (i_fmt)
      PIX_4BIT: begin
        o_pal = 1'b1;
        case (i_sub)
          2'd0:    o_idx = {4'h0, i_half[3:0]};
          2'd1:    o_idx = {4'h0, i_half[7:4]};
          2'd2:    o_idx = {4'h0, i_half[11:8]};
          default: o_idx = {4'h0, i_half[15:12]};
        endcase
      end
      PIX_8BIT: begin
        o_pal = 1'b1;
        o_idx = i_sub[0] ? i_half[15:8] : i_half[7:0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/tex_fetch_unit.sv
// Texel fetch responder: one VRAM read for the texel halfword (skipped on a
// last-halfword hit), an optional CLUT read for palette formats, and a
// registered BGR555 result held until the pixel pipeline takes it.
module tex_fetch_unit
  import tex_fetch_unit_pkg::*;
#(
  parameter bit CACHE_EN = 1'b1
) (
  input  logic        clk,
  input  logic        i_nRst,
  input  logic [1:0]  GPU_REG_TexFormat,
  input  logic [5:0]  GPU_REG_CLUTX,
  input  logic [8:0]  GPU_REG_CLUTY,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [18:0] req_adr,
  input  logic [1:0]  req_subU,
  output logic        mem_req,
  input  logic        mem_ack,
  output logic [18:0] mem_adr,
  input  logic        mem_rvalid,
  input  logic [15:0] mem_rdata,
  output logic        tex_valid,
  input  logic        tex_ready,
  output logic [15:0] tex_color,
  output logic        tex_transparent
);

  fetch_state_t r_state;
  logic [1:0]   r_fmt;
  logic [5:0]   r_clutx;
  logic [8:0]   r_cluty;
  logic [18:0]  r_adr;
  logic [1:0]   r_sub;
  logic [15:0]  r_half;
  logic [18:0]  r_hit_adr;
  logic         r_hit_valid;

  // The index is needed in two places: straight out of IDLE on a hit (live
  // request fields, cached halfword) and out of TEX_WAIT (latched fields,
  // returning read data). Everything else holds in the latched copies.
  logic        w_idle;
  logic [15:0] w_ex_half;
  logic [1:0]  w_ex_fmt;
  logic [1:0]  w_ex_sub;
  logic [5:0]  w_ex_clutx;
  logic [8:0]  w_ex_cluty;
  logic [7:0]  w_idx;
  logic        w_pal;
  logic [9:0]  w_clut_x;
  logic [18:0] w_clut_adr;
  logic        w_hit;

  assign w_idle     = (r_state == ST_IDLE);
  assign w_ex_half  = w_idle ? r_half            : mem_rdata;
  assign w_ex_fmt   = w_idle ? GPU_REG_TexFormat : r_fmt;
  assign w_ex_sub   = w_idle ? req_subU          : r_sub;
  assign w_ex_clutx = w_idle ? GPU_REG_CLUTX     : r_clutx;
  assign w_ex_cluty = w_idle ? GPU_REG_CLUTY     : r_cluty;

  texel_extract u_extract (
    .i_half (w_ex_half),
    .i_fmt  (w_ex_fmt),
    .i_sub  (w_ex_sub),
    .o_idx  (w_idx),
    .o_pal  (w_pal)
  );

  // 10-bit sum: the CLUT wraps inside its 1024-halfword VRAM line
  assign w_clut_x   = {w_ex_clutx, 4'b0000} + {2'b00, w_idx};
  assign w_clut_adr = {w_ex_cluty, w_clut_x};
  assign w_hit      = CACHE_EN && r_hit_valid && (req_adr == r_hit_adr);

  // Fetch sequencer; all outputs are registered here
  always_ff @(posedge clk or negedge i_nRst) begin
    if (!i_nRst) begin
      r_state         <= ST_IDLE;
      r_fmt           <= PIX_4BIT;
      r_clutx         <= '0;
      r_cluty         <= '0;
      r_adr           <= '0;
      r_sub           <= '0;
      r_half          <= '0;
      r_hit_adr       <= '0;
      r_hit_valid     <= 1'b0;
      req_ready       <= 1'b1;
      mem_req         <= 1'b0;
      mem_adr         <= '0;
      tex_valid       <= 1'b0;
      tex_color       <= '0;
      tex_transparent <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: if (req_valid) begin
          r_fmt     <= GPU_REG_TexFormat;
          r_clutx   <= GPU_REG_CLUTX;
          r_cluty   <= GPU_REG_CLUTY;
          r_adr     <= req_adr;
          r_sub     <= req_subU;
          req_ready <= 1'b0;
          if (w_hit && !w_pal) begin
            tex_valid       <= 1'b1;
            tex_color       <= r_half;
            tex_transparent <= (r_half == 16'h0000);
            r_state         <= ST_OUT;
          end else if (w_hit) begin
            mem_req <= 1'b1;
            mem_adr <= w_clut_adr;
            r_state <= ST_CLUT_REQ;
          end else begin
            mem_req <= 1'b1;
            mem_adr <= req_adr;
            r_state <= ST_TEX_REQ;
          end
        end
        ST_TEX_REQ: if (mem_ack) begin
          mem_req <= 1'b0;
          r_state <= ST_TEX_WAIT;
        end
        ST_TEX_WAIT: if (mem_rvalid) begin
          r_half      <= mem_rdata;
          r_hit_adr   <= r_adr;
          r_hit_valid <= 1'b1;
          if (w_pal) begin
            mem_req <= 1'b1;
            mem_adr <= w_clut_adr;
            r_state <= ST_CLUT_REQ;
          end else begin
            tex_valid       <= 1'b1;
            tex_color       <= mem_rdata;
            tex_transparent <= (mem_rdata == 16'h0000);
            r_state         <= ST_OUT;
          end
        end
        ST_CLUT_REQ: if (mem_ack) begin
          mem_req <= 1'b0;
          r_state <= ST_CLUT_WAIT;
        end
        ST_CLUT_WAIT: if (mem_rvalid) begin
          tex_valid       <= 1'b1;
          tex_color       <= mem_rdata;
          tex_transparent <= (mem_rdata == 16'h0000);
          r_state         <= ST_OUT;
        end
        ST_OUT: if (tex_ready) begin
          tex_valid <= 1'b0;
          req_ready <= 1'b1;
          r_state   <= ST_IDLE;
        end
        default: begin
          mem_req   <= 1'b0;
          tex_valid <= 1'b0;
          req_ready <= 1'b1;
          r_state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tex_fetch_unit.sv
// Bench for tex_fetch_unit: a cached instance (d=0) and an uncached one (d=1),
// a VRAM responder with programmable ack/rvalid delays, and a reference model
// that derives expected colour, VRAM read list and latency from the format rules.
module tb_tex_fetch_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic i_nRst;
  logic [1:0][1:0]  fmt;
  logic [1:0][5:0]  clutx;
  logic [1:0][8:0]  cluty;
  logic [1:0]       req_valid, req_ready, mem_req, mem_ack, mem_rvalid, stray_rv;
  logic [1:0]       tex_valid, tex_ready, tex_transparent;
  logic [1:0][18:0] req_adr, mem_adr;
  logic [1:0][1:0]  req_subU;
  logic [1:0][15:0] mem_rdata, tex_color;

  int nchk = 0, npass = 0;
  int ack_dly[2], rv_dly[2];
  int stab_err[2] = '{0, 0};
  logic [18:0] rd_log[2][$];
  logic [15:0] vmem [int];
  logic mc_valid[2] = '{1'b0, 1'b0};
  logic [18:0] mc_adr[2];

  tex_fetch_unit #(.CACHE_EN(1'b1)) u_dut (
    .clk(clk), .i_nRst(i_nRst), .GPU_REG_TexFormat(fmt[0]), .GPU_REG_CLUTX(clutx[0]),
    .GPU_REG_CLUTY(cluty[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_adr(req_adr[0]), .req_subU(req_subU[0]), .mem_req(mem_req[0]), .mem_ack(mem_ack[0]),
    .mem_adr(mem_adr[0]), .mem_rvalid(mem_rvalid[0] | stray_rv[0]), .mem_rdata(mem_rdata[0]),
    .tex_valid(tex_valid[0]), .tex_ready(tex_ready[0]), .tex_color(tex_color[0]),
    .tex_transparent(tex_transparent[0]));

  tex_fetch_unit #(.CACHE_EN(1'b0)) u_dut_nc (
    .clk(clk), .i_nRst(i_nRst), .GPU_REG_TexFormat(fmt[1]), .GPU_REG_CLUTX(clutx[1]),
    .GPU_REG_CLUTY(cluty[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_adr(req_adr[1]), .req_subU(req_subU[1]), .mem_req(mem_req[1]), .mem_ack(mem_ack[1]),
    .mem_adr(mem_adr[1]), .mem_rvalid(mem_rvalid[1] | stray_rv[1]), .mem_rdata(mem_rdata[1]),
    .tex_valid(tex_valid[1]), .tex_ready(tex_ready[1]), .tex_color(tex_color[1]),
    .tex_transparent(tex_transparent[1]));

  // VRAM contents: explicit entries, otherwise a fixed hash of the address
  function automatic logic [15:0] vram(input logic [18:0] a);
    int v;
    if (vmem.exists(int'(a))) return vmem[int'(a)];
    v = (int'(a) * 40503) ^ (int'(a) >> 5);
    return v[15:0];
  endfunction

  // CLUT halfword address for a palette texel
  function automatic logic [18:0] clut_of(input logic [1:0] f, input logic [15:0] h,
                                          input logic [1:0] s, input logic [5:0] cx, input logic [8:0] cy);
    int idx;
    if (f == 2'd0) idx = (int'(h) >> (4 * int'(s))) & 15;
    else           idx = s[0] ? ((int'(h) >> 8) & 255) : (int'(h) & 255);
    return 19'(int'(cy) * 1024 + (int'(cx) * 16 + idx) % 1024);
  endfunction

  // Memory responder: ack after ack_dly waiting cycles, rvalid rv_dly cycles after ack;
  // also flags any change of a pending request before it is acked
  int req_cnt[2] = '{0, 0}, rv_cnt[2] = '{-1, -1};
  logic [18:0] rv_adr[2], last_adr[2];
  logic last_req[2] = '{1'b0, 1'b0};
  always @(negedge clk or negedge i_nRst) begin
    if (!i_nRst) begin
      mem_ack = '0; mem_rvalid = '0; mem_rdata = '0;
      for (int d = 0; d < 2; d++) begin req_cnt[d] = 0; rv_cnt[d] = -1; last_req[d] = 1'b0; end
    end else begin
      for (int d = 0; d < 2; d++) begin
        mem_ack[d] = 1'b0; mem_rvalid[d] = 1'b0;
        if (last_req[d] && !(mem_req[d] === 1'b1 && mem_adr[d] === last_adr[d])) stab_err[d]++;
        if (rv_cnt[d] > 0) rv_cnt[d]--;
        else if (rv_cnt[d] == 0) begin
          mem_rvalid[d] = 1'b1; mem_rdata[d] = vram(rv_adr[d]); rv_cnt[d] = -1;
        end
        if (mem_req[d] === 1'b1) begin
          req_cnt[d]++;
          if (req_cnt[d] > ack_dly[d]) begin
            mem_ack[d] = 1'b1; rd_log[d].push_back(mem_adr[d]);
            rv_adr[d] = mem_adr[d]; rv_cnt[d] = rv_dly[d] - 1; req_cnt[d] = 0;
          end
        end else req_cnt[d] = 0;
        last_req[d] = (mem_req[d] === 1'b1) && !mem_ack[d];
        last_adr[d] = mem_adr[d];
      end
    end
  end

  // One request through DUT d; exp_lat=0 skips the latency comparison
  task automatic run_req(input int d, input logic [1:0] f, input logic [18:0] a, input logic [1:0] s,
                         input logic [5:0] cx, input logic [8:0] cy, input int hold, input int exp_lat,
                         input string nm);
    logic hit, is16, bad_rdy, bad_hold;
    logic [15:0] h, exp_c, c0;
    logic [18:0] ca;
    logic [18:0] exp_q[$];
    int n0, lat, w;
    bit rd_ok;
    is16 = f[1];
    hit = (d == 0) && mc_valid[d] && (mc_adr[d] == a);
    h = vram(a);
    ca = clut_of(f, h, s, cx, cy);
    exp_c = is16 ? h : vram(ca);
    if (!hit) exp_q.push_back(a);
    if (!is16) exp_q.push_back(ca);
    if (!hit) begin mc_valid[d] = 1'b1; mc_adr[d] = a; end
    if (exp_lat < 0) exp_lat = hit ? (is16 ? 1 : 4) : (is16 ? 4 : 7);
    n0 = rd_log[d].size();
    w = 0;
    while (req_ready[d] !== 1'b1 && w < 100) begin @(posedge clk); #1; w++; end
    fmt[d] = f; clutx[d] = cx; cluty[d] = cy; req_adr[d] = a; req_subU[d] = s; req_valid[d] = 1'b1;
    @(posedge clk); #1;
    req_valid[d] = 1'b0;
    fmt[d] = 2'($urandom); clutx[d] = 6'($urandom); cluty[d] = 9'($urandom);
    req_adr[d] = 19'($urandom); req_subU[d] = 2'($urandom);
    lat = 1; bad_rdy = 1'b0;
    while (tex_valid[d] !== 1'b1 && lat < 400) begin
      if (req_ready[d] !== 1'b0) bad_rdy = 1'b1;
      @(posedge clk); #1; lat++;
    end
    nchk++;
    if (tex_valid[d] !== 1'b1) $display("FAIL %s timeout: tex_valid=%b after %0d cycles, required 1", nm, tex_valid[d], lat);
    else npass++;
    nchk++;
    if (tex_color[d] !== exp_c) $display("FAIL %s color: got %h required %h", nm, tex_color[d], exp_c);
    else npass++;
    nchk++;
    if (tex_transparent[d] !== (exp_c == 16'h0000))
      $display("FAIL %s transparent: got %b required %b", nm, tex_transparent[d], exp_c == 16'h0000);
    else npass++;
    if (exp_lat > 0) begin
      nchk++;
      if (lat !== exp_lat) $display("FAIL %s latency: got %0d required %0d", nm, lat, exp_lat);
      else npass++;
    end
    c0 = tex_color[d]; bad_hold = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (tex_valid[d] !== 1'b1 || tex_color[d] !== c0) bad_hold = 1'b1;
      if (req_ready[d] !== 1'b0) bad_rdy = 1'b1;
    end
    if (hold > 0) begin
      nchk++;
      if (bad_hold) $display("FAIL %s hold: output changed before tex_ready, got %h required %h", nm, tex_color[d], c0);
      else npass++;
    end
    nchk++;
    if (bad_rdy) $display("FAIL %s req_ready: got 1 during fetch, required 0", nm);
    else npass++;
    tex_ready[d] = 1'b1;
    @(posedge clk); #1;
    tex_ready[d] = 1'b0;
    nchk++;
    if (req_ready[d] !== 1'b1 || tex_valid[d] !== 1'b0)
      $display("FAIL %s release: req_ready=%b tex_valid=%b required 1/0", nm, req_ready[d], tex_valid[d]);
    else npass++;
    rd_ok = (rd_log[d].size() - n0) == exp_q.size();
    if (rd_ok) foreach (exp_q[i]) if (rd_log[d][n0 + i] !== exp_q[i]) rd_ok = 0;
    nchk++;
    if (!rd_ok) $display("FAIL %s reads: got %0d reads required %0d (first required %h)",
                         nm, rd_log[d].size() - n0, exp_q.size(), (exp_q.size() > 0) ? exp_q[0] : 19'h0);
    else npass++;
  endtask

  task automatic test_reset;
    i_nRst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    nchk++;
    if (req_ready !== 2'b11 || mem_req !== 2'b00 || tex_valid !== 2'b00)
      $display("FAIL reset ctrl: ready=%b req=%b valid=%b required 11/00/00", req_ready, mem_req, tex_valid);
    else npass++;
    nchk++;
    if (mem_adr[0] !== 19'h0 || tex_color[0] !== 16'h0 || tex_transparent[0] !== 1'b1)
      $display("FAIL reset data: adr=%h color=%h transp=%b required 0/0/1", mem_adr[0], tex_color[0], tex_transparent[0]);
    else npass++;
    @(negedge clk); i_nRst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_16bit_miss;
    vmem[32'h12345] = 16'h7C1F;
    run_req(0, 2'd2, 19'h12345, 2'd0, 6'd9, 9'd3, 0, -1, "miss16");
  endtask

  task automatic test_4bit_clut;
    vmem[32'h00200] = 16'hA000;
    vmem[480 * 1024 + 42] = 16'h0000;
    run_req(0, 2'd0, 19'h00200, 2'd3, 6'd2, 9'd480, 0, -1, "clut4");
    nchk++;
    if (rd_log[0][rd_log[0].size() - 1] !== 19'(480 * 1024 + 42))
      $display("FAIL clut4 adr: got %h required %h", rd_log[0][rd_log[0].size() - 1], 19'(480 * 1024 + 42));
    else npass++;
  endtask

  task automatic test_8bit_wrap;
    vmem[32'h00300] = 16'h2000;
    vmem[5 * 1024 + 16] = 16'h1234;
    run_req(0, 2'd1, 19'h00300, 2'd1, 6'd63, 9'd5, 0, -1, "clut8wrap");
    nchk++;
    if (rd_log[0][rd_log[0].size() - 1] !== 19'(5 * 1024 + 16))
      $display("FAIL clut8wrap adr: got %h required %h", rd_log[0][rd_log[0].size() - 1], 19'(5 * 1024 + 16));
    else npass++;
  endtask

  task automatic test_cache;
    run_req(0, 2'd2, 19'h00100, 2'd0, 6'd1, 9'd1, 0, 4, "cache_fill");
    run_req(0, 2'd2, 19'h00100, 2'd0, 6'd1, 9'd1, 0, 1, "cache_hit16");
    run_req(0, 2'd1, 19'h00100, 2'd1, 6'd7, 9'd2, 0, 4, "cache_hit8");
    run_req(1, 2'd2, 19'h00100, 2'd0, 6'd1, 9'd1, 0, 4, "nocache_1");
    run_req(1, 2'd2, 19'h00100, 2'd0, 6'd1, 9'd1, 0, 4, "nocache_2");
  endtask

  // req_valid held high: the tex_ready cycle must not accept, IDLE comes first
  task automatic test_back_to_back;
    fmt[0] = 2'd2; req_adr[0] = 19'h00100; req_valid[0] = 1'b1; tex_ready[0] = 1'b1;
    @(posedge clk); #1;
    nchk++;
    if (tex_valid[0] !== 1'b1 || req_ready[0] !== 1'b0)
      $display("FAIL b2b first: valid=%b ready=%b required 1/0", tex_valid[0], req_ready[0]);
    else npass++;
    @(posedge clk); #1;
    nchk++;
    if (tex_valid[0] !== 1'b0 || req_ready[0] !== 1'b1)
      $display("FAIL b2b idle gap: valid=%b ready=%b required 0/1", tex_valid[0], req_ready[0]);
    else npass++;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    nchk++;
    if (tex_valid[0] !== 1'b1 || tex_color[0] !== vram(19'h00100))
      $display("FAIL b2b second: valid=%b color=%h required 1/%h", tex_valid[0], tex_color[0], vram(19'h00100));
    else npass++;
    @(posedge clk); #1;
    tex_ready[0] = 1'b0;
  endtask

  task automatic test_backpressure;
    ack_dly[0] = 5;
    run_req(0, 2'd0, 19'h04444, 2'd1, 6'd12, 9'd77, 3, 15, "backpressure");
    ack_dly[0] = 1;
    nchk++;
    if (stab_err[0] !== 0) $display("FAIL mem_hold: %0d unstable request cycles, required 0", stab_err[0]);
    else npass++;
  endtask

  task automatic test_random;
    for (int i = 0; i < 30; i++) begin
      ack_dly[0] = $urandom_range(0, 3);
      rv_dly[0]  = $urandom_range(1, 3);
      run_req(0, 2'($urandom), 19'h30000 + 19'($urandom_range(0, 3)), 2'($urandom),
              6'($urandom), 9'($urandom), $urandom_range(0, 2), 0, "random");
    end
    ack_dly[0] = 1; rv_dly[0] = 1;
  endtask

  task automatic test_reset_midfetch;
    int n0, w;
    bit bad;
    rv_dly[0] = 30;
    n0 = rd_log[0].size();
    fmt[0] = 2'd0; clutx[0] = 6'd3; cluty[0] = 9'd9; req_adr[0] = 19'h05555; req_subU[0] = 2'd2;
    req_valid[0] = 1'b1;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    w = 0;
    while (rd_log[0].size() < n0 + 2 && w < 200) begin @(posedge clk); #1; w++; end
    nchk++;
    if (rd_log[0].size() < n0 + 2) $display("FAIL midreset reach: %0d reads, required 2", rd_log[0].size() - n0);
    else npass++;
    #2 i_nRst = 1'b0;
    #1;
    nchk++;
    if (req_ready[0] !== 1'b1 || mem_req[0] !== 1'b0 || mem_adr[0] !== 19'h0 || tex_valid[0] !== 1'b0 ||
        tex_color[0] !== 16'h0 || tex_transparent[0] !== 1'b1)
      $display("FAIL midreset async: ready=%b req=%b adr=%h valid=%b color=%h transp=%b required 1/0/0/0/0/1",
               req_ready[0], mem_req[0], mem_adr[0], tex_valid[0], tex_color[0], tex_transparent[0]);
    else npass++;
    mc_valid[0] = 1'b0; mc_valid[1] = 1'b0;
    rv_dly[0] = 1;
    repeat (2) @(posedge clk);
    #3 i_nRst = 1'b1;
    @(posedge clk); #1 stray_rv[0] = 1'b1;
    @(posedge clk); #1 stray_rv[0] = 1'b0;
    bad = 0;
    repeat (4) begin
      if (tex_valid[0] !== 1'b0 || req_ready[0] !== 1'b1 || mem_req[0] !== 1'b0) bad = 1;
      @(posedge clk); #1;
    end
    nchk++;
    if (bad) $display("FAIL stray rvalid: valid=%b ready=%b req=%b required 0/1/0", tex_valid[0], req_ready[0], mem_req[0]);
    else npass++;
    // cache was flushed by reset: the same address is a miss again
    run_req(0, 2'd2, 19'h00100, 2'd0, 6'd0, 9'd0, 0, 4, "post_reset_miss");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    i_nRst = 1'b0;
    fmt = '0; clutx = '0; cluty = '0; req_valid = '0; req_adr = '0; req_subU = '0;
    tex_ready = '0; stray_rv = '0;
    ack_dly = '{1, 1}; rv_dly = '{1, 1};
    test_reset;
    test_16bit_miss;
    test_4bit_clut;
    test_8bit_wrap;
    test_cache;
    test_back_to_back;
    test_backpressure;
    test_random;
    test_reset_midfetch;
    nchk++;
    if (stab_err[0] !== 0 || stab_err[1] !== 0)
      $display("FAIL mem_hold_final: %0d/%0d unstable request cycles, required 0", stab_err[0], stab_err[1]);
    else npass++;
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
